// File: rtl/timer_bank_if.sv
// Control/status bundle between the lab control FSMs and the timer bank.
// The master drives configuration and strobes; the slave returns channel status.
interface timer_bank_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int CH_BITS  = 2
) ();
   logic                cfg_we;
   logic [CH_BITS-1:0]  cfg_ch;
   logic [WIDTH-1:0]    cfg_term;
   logic                cfg_periodic;
   logic [CHANNELS-1:0] start;
   logic [CHANNELS-1:0] cancel;
   logic [CHANNELS-1:0] busy;
   logic [CHANNELS-1:0] done;
   logic [CHANNELS-1:0] tick;

   modport master (
      output cfg_we, cfg_ch, cfg_term, cfg_periodic, start, cancel,
      input  busy, done, tick
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_term, cfg_periodic, start, cancel,
      output busy, done, tick
   );
endinterface

// File: rtl/timer_bank.sv
// Bank of independent countdown/interval timers with programmable terminal count,
// one-shot or periodic mode, cancel, and sticky done / single-cycle tick outputs.
module timer_bank #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int CH_BITS  = 2
) (
   input logic         clk,
   input logic         reset,
   timer_bank_if.slave bus
);

   // Encoding chosen so busy and done are each a single state flop bit.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   logic [WIDTH-1:0]    term_q     [CHANNELS];
   logic [WIDTH-1:0]    count_q    [CHANNELS];
   logic [1:0]          state_q    [CHANNELS];
   logic [CHANNELS-1:0] periodic_q;
   logic [CHANNELS-1:0] tick_q;

   // NOTE: term_q is a small register file, not a RAM, so it is reset along with
   // every other flop; the channels must come up with term=0 and one-shot mode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         periodic_q <= '0;
         tick_q     <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            term_q[i]  <= '0;
            count_q[i] <= '0;
            state_q[i] <= ST_IDLE;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            // Matching against i drops cfg_ch values >= CHANNELS without an
            // out-of-range array index.
            if (bus.cfg_we && (32'(bus.cfg_ch) == i)) begin
               term_q[i]     <= bus.cfg_term;
               periodic_q[i] <= bus.cfg_periodic;
            end

            // NOTE: non-blocking assignment means a later assignment in this
            // iteration overrides this default at the edge, with no ordering race.
            tick_q[i] <= 1'b0;

            if (bus.cancel[i]) begin
               state_q[i] <= ST_IDLE;
               count_q[i] <= '0;
            end else if (bus.start[i]) begin
               state_q[i] <= ST_RUN;
               count_q[i] <= '0;
            end else if (state_q[i] == ST_RUN) begin
               // >= so a term lowered below the running count expires at once.
               if (count_q[i] >= term_q[i]) begin
                  tick_q[i] <= 1'b1;
                  if (periodic_q[i]) begin
                     count_q[i] <= '0;
                  end else begin
                     state_q[i] <= ST_DONE;
                  end
               end else begin
                  count_q[i] <= count_q[i] + WIDTH'(1);
               end
            end
         end
      end
   end

   always_comb begin
      bus.busy = '0;
      bus.done = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         bus.busy[i] = state_q[i][0];
         bus.done[i] = state_q[i][1];
      end
   end

   assign bus.tick = tick_q;

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank: a 4-channel instance for the main
// behaviour and a 3-channel instance for the out-of-range configuration write.
module tb_timer_bank;

   logic clk;
   logic reset;

   int n_checks = 0;
   int n_fail   = 0;

   timer_bank_if #(.WIDTH(32), .CHANNELS(4), .CH_BITS(2)) bus ();
   timer_bank_if #(.WIDTH(32), .CHANNELS(3), .CH_BITS(2)) bus3 ();

   timer_bank #(.WIDTH(32), .CHANNELS(4), .CH_BITS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   timer_bank #(.WIDTH(32), .CHANNELS(3), .CH_BITS(2)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs set afterwards are sampled by the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] ch, input logic [31:0] term, input logic per);
      bus.cfg_we       = 1'b1;
      bus.cfg_ch       = ch;
      bus.cfg_term     = term;
      bus.cfg_periodic = per;
      step();
      bus.cfg_we       = 1'b0;
   endtask

   task automatic cfg3(input logic [1:0] ch, input logic [31:0] term, input logic per);
      bus3.cfg_we       = 1'b1;
      bus3.cfg_ch       = ch;
      bus3.cfg_term     = term;
      bus3.cfg_periodic = per;
      step();
      bus3.cfg_we       = 1'b0;
   endtask

   logic [2:0] exp3_done [6];
   logic [2:0] exp3_tick [6];
   logic [2:0] exp3_busy [6];

   initial begin
      reset = 1'b1;
      bus.cfg_we  = 1'b0; bus.cfg_ch  = '0; bus.cfg_term  = '0; bus.cfg_periodic  = 1'b0;
      bus.start   = '0;   bus.cancel  = '0;
      bus3.cfg_we = 1'b0; bus3.cfg_ch = '0; bus3.cfg_term = '0; bus3.cfg_periodic = 1'b0;
      bus3.start  = '0;   bus3.cancel = '0;

      // Reset state
      step(); step();
      check("rst_busy", bus.busy, 4'b0000);
      check("rst_done", bus.done, 4'b0000);
      check("rst_tick", bus.tick, 4'b0000);
      reset = 1'b0;
      step();

      // ch0 one-shot, term=5: done rises 6 edges after the start edge
      cfg(2'd0, 32'd5, 1'b0);
      bus.start = 4'b0001;
      step();
      bus.start = '0;
      check("os_busy_k", bus.busy[0], 1'b1);
      check("os_done_k", bus.done[0], 1'b0);
      for (int c = 1; c <= 5; c++) begin
         step();
         check("os_tick_pre", bus.tick[0], 1'b0);
         check("os_done_pre", bus.done[0], 1'b0);
         check("os_busy_pre", bus.busy[0], 1'b1);
      end
      step();
      check("os_tick_k6", bus.tick[0], 1'b1);
      check("os_done_k6", bus.done[0], 1'b1);
      check("os_busy_k6", bus.busy[0], 1'b0);
      for (int c = 0; c < 20; c++) begin
         step();
         check("os_done_hold", bus.done[0], 1'b1);
         check("os_tick_hold", bus.tick[0], 1'b0);
      end

      // ch1 periodic, term=3: tick every 4 cycles, never done; then cancel
      cfg(2'd1, 32'd3, 1'b1);
      bus.start = 4'b0010;
      step();
      bus.start = '0;
      for (int c = 1; c <= 20; c++) begin
         step();
         check("per_tick", bus.tick[1], (c % 4 == 0) ? 1'b1 : 1'b0);
         check("per_done", bus.done[1], 1'b0);
         check("per_busy", bus.busy[1], 1'b1);
      end
      bus.cancel = 4'b0010;
      step();
      bus.cancel = '0;
      check("cancel_busy", bus.busy[1], 1'b0);
      check("cancel_tick", bus.tick[1], 1'b0);
      for (int c = 0; c < 8; c++) begin
         step();
         check("cancel_no_tick", bus.tick[1], 1'b0);
      end

      // ch2 term=100 lowered to 4 while count=10: expiry on the following edge
      cfg(2'd2, 32'd100, 1'b0);
      bus.start = 4'b0100;
      step();
      bus.start = '0;
      for (int c = 1; c <= 10; c++) step();
      bus.cfg_we = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_term = 32'd4; bus.cfg_periodic = 1'b0;
      step();
      bus.cfg_we = 1'b0;
      check("lower_tick_wr", bus.tick[2], 1'b0);
      check("lower_busy_wr", bus.busy[2], 1'b1);
      step();
      check("lower_tick", bus.tick[2], 1'b1);
      check("lower_done", bus.done[2], 1'b1);
      check("lower_busy", bus.busy[2], 1'b0);
      for (int c = 0; c < 6; c++) begin
         step();
         check("lower_done_hold", bus.done[2], 1'b1);
         check("lower_no_wrap", bus.tick[2], 1'b0);
      end

      // ch3 start+cancel together while running; ch0..2 start on the same edge
      cfg(2'd0, 32'd2, 1'b0);
      cfg(2'd1, 32'd2, 1'b1);
      cfg(2'd2, 32'd2, 1'b0);
      cfg(2'd3, 32'd50, 1'b0);
      bus.start = 4'b1000;
      step();
      bus.start = '0;
      step(); step();
      check("ch3_running", bus.busy[3], 1'b1);
      bus.start  = 4'b1111;
      bus.cancel = 4'b1000;
      step();
      bus.start  = '0;
      bus.cancel = '0;
      check("sc_busy", bus.busy, 4'b0111);
      check("sc_done", bus.done, 4'b0000);
      check("sc_tick", bus.tick, 4'b0000);
      step(); step();
      check("sc_tick_k2", bus.tick, 4'b0000);
      step();
      check("sc_tick_k3", bus.tick, 4'b0111);
      check("sc_done_k3", bus.done, 4'b0101);
      check("sc_busy_k3", bus.busy, 4'b0010);

      // Asynchronous reset mid-period with every channel running
      cfg(2'd0, 32'd7, 1'b1);
      cfg(2'd2, 32'd9, 1'b1);
      cfg(2'd3, 32'd11, 1'b1);
      bus.start = 4'b1111;
      step();
      bus.start = '0;
      check("all_busy", bus.busy, 4'b1111);
      step(); step(); step();
      check("pre_rst_tick", bus.tick, 4'b0010);
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy", bus.busy, 4'b0000);
      check("arst_done", bus.done, 4'b0000);
      check("arst_tick", bus.tick, 4'b0000);
      step();
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         check("post_rst_tick", bus.tick, 4'b0000);
         check("post_rst_busy", bus.busy, 4'b0000);
      end

      // Restart on the expiry edge: start wins and no tick is produced
      cfg(2'd0, 32'd2, 1'b0);
      bus.start = 4'b0001;
      step();
      bus.start = '0;
      step(); step();
      bus.start = 4'b0001;
      step();
      bus.start = '0;
      check("restart_tick", bus.tick[0], 1'b0);
      check("restart_busy", bus.busy[0], 1'b1);
      check("restart_done", bus.done[0], 1'b0);
      step(); step();
      check("restart_tick_pre", bus.tick[0], 1'b0);
      step();
      check("restart_tick_exp", bus.tick[0], 1'b1);
      check("restart_done_exp", bus.done[0], 1'b1);

      // 3-channel instance: write to cfg_ch=3 must not touch any channel
      exp3_done = '{3'b000, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011};
      exp3_tick = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b000, 3'b100};
      exp3_busy = '{3'b111, 3'b101, 3'b101, 3'b100, 3'b100, 3'b100};
      cfg3(2'd0, 32'd3, 1'b0);
      cfg3(2'd1, 32'd1, 1'b0);
      cfg3(2'd2, 32'd2, 1'b1);
      cfg3(2'd3, 32'd0, 1'b1);
      bus3.start = 3'b111;
      step();
      bus3.start = '0;
      check("oor_busy_k", bus3.busy, 3'b111);
      for (int c = 1; c <= 6; c++) begin
         step();
         check("oor_done", bus3.done, exp3_done[c-1]);
         check("oor_tick", bus3.tick, exp3_tick[c-1]);
         check("oor_busy", bus3.busy, exp3_busy[c-1]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
